// File: rtl/decoder_n_to_m_seq.sv
`default_nettype none
// ============================================================================
//  Module     : decoder_n_to_m_seq
//  Description: Registered N-to-2^N one-hot decoder with a valid/ready input,
//               an active-level option and an optional auto-scan mode
//               (compiled in with DECODER_SCAN_EN).
//  Revision   : 1.0 - initial release
// ============================================================================
module decoder_n_to_m_seq #(
    parameter int N          = 2,
    parameter int SCAN_DWELL = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         sel,
    input  logic                 en,
    input  logic                 mode,
    output logic [(1<<N)-1:0]    out,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int                 c_LINES    = 1 << N;
    localparam logic [c_LINES-1:0] c_INACTIVE = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_LINES-1:0] r_out;
    logic               r_out_valid;
    logic               w_accept;

    function automatic logic [c_LINES-1:0] f_onehot(input logic [N-1:0] idx);
        logic [c_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Polarity is applied before the register so the pins come straight off flops.
    function automatic logic [c_LINES-1:0] f_drive(input logic [c_LINES-1:0] pattern);
        return ACTIVE_LOW ? ~pattern : pattern;
    endfunction

    assign w_accept  = in_valid && in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef DECODER_SCAN_EN
    localparam int              c_DW         = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(SCAN_DWELL - 1);

    logic [c_DW-1:0] r_dwell;
    logic [N-1:0]    r_index;
    logic [N-1:0]    w_index_next;
    logic            r_scan_wrap;

    assign w_index_next = r_index + N'(1);
    assign in_ready     = (r_state != ST_SCAN) && !mode;
    assign scan_wrap    = r_scan_wrap;
`else
    logic w_mode_unused;

    assign w_mode_unused = mode;
    assign in_ready      = 1'b1;
    assign scan_wrap     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out       <= c_INACTIVE;
            r_out_valid <= 1'b0;
`ifdef DECODER_SCAN_EN
            r_dwell     <= '0;
            r_index     <= '0;
            r_scan_wrap <= 1'b0;
`endif
        end else begin
`ifdef DECODER_SCAN_EN
            r_scan_wrap <= 1'b0;
`endif
            case (r_state)
`ifdef DECODER_SCAN_EN
                ST_SCAN: begin
                    if (!mode) begin
                        // Leaving scan drops any partial dwell.
                        r_state     <= ST_IDLE;
                        r_out       <= c_INACTIVE;
                        r_out_valid <= 1'b0;
                        r_dwell     <= '0;
                        r_index     <= '0;
                    end else if (r_dwell == c_DWELL_LAST) begin
                        r_dwell     <= '0;
                        r_index     <= w_index_next;
                        r_out       <= f_drive(f_onehot(w_index_next));
                        r_scan_wrap <= (r_index == N'(c_LINES - 1));
                    end else begin
                        r_dwell <= r_dwell + c_DW'(1);
                    end
                end
`endif
                default: begin
`ifdef DECODER_SCAN_EN
                    if (mode) begin
                        r_state     <= ST_SCAN;
                        r_dwell     <= '0;
                        r_index     <= '0;
                        r_out       <= f_drive(f_onehot('0));
                        r_out_valid <= 1'b1;
                    end else
`endif
                    if (w_accept) begin
                        r_state     <= ST_HOLD;
                        r_out       <= en ? f_drive(f_onehot(sel)) : c_INACTIVE;
                        r_out_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/decoder_n_to_m_seq.md
# decoder_n_to_m_seq

Parametrised, registered binary-to-one-hot decoder that generalises the 2-to-4 decoder to N select bits and 2^N outputs. It adds a valid/ready input handshake, an output enable and active-level option, and an optional auto-scan mode that walks the one-hot output through every line with a programmable dwell. It sits between control logic and row/column or chip-select fan-out, for example in display multiplexing or peripheral selection.

## Interface
- N, default 2: select width. Legal range is 1..6. Output width is 2^N.
- SCAN_DWELL, default 4: cycles each line stays active in scan mode. Must be at least 1.
- ACTIVE_LOW, default 0: when 1, every bit of `out` is inverted, so the active line is 0 and inactive lines are 1.
- clk, input, 1: single clock. All logic is rising-edge.
- rst_n, input, 1: reset. Asynchronous assert, active-low.
- in_valid, input, 1: `sel` and `en` are presented.
- in_ready, output, 1: the block can accept a transaction.
- sel, input, N: line index to decode.
- en, input, 1: sampled with `sel`. When 0, the decoded pattern has no active line.
- mode, input, 1: 0 selects direct mode, 1 selects scan mode. Level-sensitive.
- out, output, 2^N: registered decoded lines, polarity set by ACTIVE_LOW.
- out_valid, output, 1: `out` holds a decoded or scanned pattern.
- scan_wrap, output, 1: one-cycle pulse when the scan index wraps from 2^N-1 to 0.

## Operation
- The FSM has three states: IDLE, HOLD and SCAN. Reset enters IDLE.
- in_ready = (state != SCAN) && !mode. It is combinational from state and `mode`.
- IDLE:
  - `out` is all inactive and out_valid = 0.
  - An accept (in_valid && in_ready) goes to HOLD.
  - mode = 1 goes to SCAN.
- HOLD:
  - `out` = onehot(sel) when the sampled en = 1, otherwise all inactive.
  - out_valid = 1, including when en = 0.
  - The pattern is held until the next accept, which reloads it with no bubble.
  - mode = 1 goes to SCAN.
- SCAN:
  - The index starts at 0 and `out` = onehot(index).
  - The dwell counter runs from 0 to SCAN_DWELL-1. At terminal count, index increments modulo 2^N and the dwell counter clears.
  - scan_wrap pulses high on the cycle `out` shows line 0 again after line 2^N-1. There is no pulse on scan entry.
  - mode = 0 goes to IDLE on the next edge: `out` clears and out_valid drops. The partial dwell is abandoned.
  - `en` is ignored in SCAN.
- mode = 1 and in_valid = 1 in the same cycle: mode wins. in_ready is 0, so no accept occurs.
- `sel` out of range cannot occur, because the width is exactly N.
- Dwell counter width is $clog2(SCAN_DWELL), with a minimum of 1 bit. Index width is N. Both wrap with no overflow state.

## Timing
- Reset values: `out` is all inactive (all 0, or all 1 when ACTIVE_LOW = 1), out_valid = 0, scan_wrap = 0. After release, in_ready = !mode.
- Direct latency is 1 cycle. Accept at edge k gives `out` and out_valid updated after edge k.
- Back-to-back accepts are allowed every cycle. Throughput is 1 per cycle.
- Scan entry: mode rises before edge k, and line 0 is active after edge k. Each line is active for exactly SCAN_DWELL cycles. The full period is SCAN_DWELL × 2^N cycles.
- Reset asserted mid-scan or mid-hold forces the reset values immediately, without waiting for a clock edge.

## Configuration
- DECODER_SCAN_EN defined: SCAN state, dwell counter, index counter and scan_wrap logic are present, and `mode` behaves as above.
- DECODER_SCAN_EN undefined:
  - The `mode` port remains but is ignored and treated as 0.
  - in_ready = 1 whenever out of reset.
  - scan_wrap is tied to 0.
  - The SCAN state and its counters are not synthesised.

## Test plan
All scenarios use N = 2, SCAN_DWELL = 4 and ACTIVE_LOW = 0 unless stated otherwise.
- Reset, then direct decode: accept sel = 0,1,2,3 with en = 1 on consecutive cycles. `out` must read 0001, 0010, 0100, 1000, each one cycle after its accept, with out_valid = 1 from the first.
- Enable off: accept sel = 2 with en = 0. `out` = 0000 and out_valid = 1. Then accept sel = 2 with en = 1, and `out` = 0100.
- Scan mode (macro defined): assert mode. `out` = 0001 for 4 cycles, then 0010, 0100, 1000. scan_wrap pulses once on the return to 0001, at cycle 17 after entry. in_ready stays 0 throughout.
- Collision and exit: in IDLE, drive mode = 1 and in_valid = 1 together. No accept occurs and SCAN is entered. Drop mode mid-dwell on line 2; the next cycle shows `out` = 0000, out_valid = 0 and in_ready = 1.
- Active-low: with ACTIVE_LOW = 1, the reset value of `out` is 1111. Accept sel = 1 with en = 1, and `out` = 1101.
- Async reset: assert rst_n low during scan on line 3, between clock edges. `out`, out_valid and scan_wrap must return to their reset values before the next clock edge.
